// File: rtl/scsi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scsi_bus_pkg
// Description : Shared types and defaults for the WD33C93 bus-port arbiter.
//               It holds the phase state encoding, the port-owner codes,
//               the default timing constants and the arbitration helper.
// Revision    : 1.0  initial release
// ============================================================================
package scsi_bus_pkg;

    // Bus-port phase sequence for a single WD access
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Current or most recent owner of the WD port
    typedef enum logic {
        GNT_CPU_OWN = 1'b0,
        GNT_DMA_OWN = 1'b1
    } owner_e;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 3;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_CNT_W      = 3;

    // Choose an owner from the eligible requests. On a tie the side that
    // did not win last time gets the port. Callers must ensure that at
    // least one request is eligible.
    function automatic owner_e arb_pick(input logic cpu_elig,
                                        input logic dma_elig,
                                        input owner_e last_gnt);
        owner_e pick;
        if (cpu_elig && dma_elig) begin
            pick = (last_gnt == GNT_CPU_OWN) ? GNT_DMA_OWN : GNT_CPU_OWN;
        end else if (cpu_elig) begin
            pick = GNT_CPU_OWN;
        end else begin
            pick = GNT_DMA_OWN;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scsi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : scsi_bus_arbiter_if
// Description : Request, grant and WD33C93 strobe signals of the bus-port
//               arbiter. Active-low WD pins carry an _n suffix. The master
//               side is the requester/board view. The slave side is the
//               arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface scsi_bus_arbiter_if;
    logic cpu_req;      // decoded, AS_-qualified CPU register cycle
    logic cpu_rw;       // 1 = read WD register
    logic dma_req;      // WD DREQ, already synchronised
    logic dma_rw;       // 1 = SCSI -> memory
    logic dma_en;       // DMA enable from control register
    logic gnt_cpu;
    logic gnt_dma;
    logic scsi_cs_n;
    logic scsi_dack_n;
    logic scsi_re_n;
    logic scsi_we_n;
    logic data_le;
    logic cpu_ack;
    logic dma_ack;

    modport master (
        output cpu_req, cpu_rw, dma_req, dma_rw, dma_en,
        input  gnt_cpu, gnt_dma, scsi_cs_n, scsi_dack_n, scsi_re_n,
               scsi_we_n, data_le, cpu_ack, dma_ack
    );

    modport slave (
        input  cpu_req, cpu_rw, dma_req, dma_rw, dma_en,
        output gnt_cpu, gnt_dma, scsi_cs_n, scsi_dack_n, scsi_re_n,
               scsi_we_n, data_le, cpu_ack, dma_ack
    );
endinterface
`default_nettype wire

// File: rtl/scsi_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : scsi_phase_timer
// Description : Loadable down-counter that times every bus phase. It
//               reports a zero flag for the current count and for the
//               count that follows the next edge. The second flag lets
//               registered outputs mark the final cycle of a phase.
// Revision    : 1.0  initial release
// ============================================================================
module scsi_phase_timer
    import scsi_bus_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o,
    output logic             zero_next_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load on phase entry, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o      = (cnt_q == '0);
    assign zero_next_o = (cnt_d == '0);

endmodule
`default_nettype wire

// File: rtl/scsi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scsi_bus_arbiter
// Description : Arbitrates the WD33C93 bus port between CPU register cycles
//               and DMA FIFO transfers. It sequences CS_/DACK_ and RE_/WE_
//               through the SETUP, STROBE and HOLD phases. All outputs are
//               registered.
// Config      : define SCSI_BURST_EN to let a DMA grant run up to BURST_LEN
//               back-to-back transfers without an IDLE turnaround.
// Revision    : 1.0  initial release
// ============================================================================
module scsi_bus_arbiter
    import scsi_bus_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    scsi_bus_arbiter_if.slave  bus_if
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    // Reject phase lengths that the counter cannot represent
    if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX) begin : g_bad_setup
        $error("SETUP_CYC out of range for CNT_W");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > CNT_MAX) begin : g_bad_strobe
        $error("STROBE_CYC out of range for CNT_W");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > CNT_MAX) begin : g_bad_hold
        $error("HOLD_CYC out of range for CNT_W");
    end
    if (BURST_LEN < 1) begin : g_bad_burst
        $error("BURST_LEN must be at least 1");
    end

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e last_gnt_q, last_gnt_d;
    logic   rw_q, rw_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             tmr_zero_next;

    logic gnt_cpu_q, gnt_cpu_d;
    logic gnt_dma_q, gnt_dma_d;
    logic cs_n_q, cs_n_d;
    logic dack_n_q, dack_n_d;
    logic re_n_q, re_n_d;
    logic we_n_q, we_n_d;
    logic data_le_q, data_le_d;
    logic cpu_ack_q, cpu_ack_d;
    logic dma_ack_q, dma_ack_d;

    logic cpu_elig;
    logic dma_elig;
    logic owner_req;

    assign cpu_elig  = bus_if.cpu_req;
    assign dma_elig  = bus_if.dma_req && bus_if.dma_en;
    // Abort tracks the raw request. DMA_EN only gates new grants.
    assign owner_req = (owner_q == GNT_CPU_OWN) ? bus_if.cpu_req : bus_if.dma_req;

`ifdef SCSI_BURST_EN
    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN);
    logic [BURST_W-1:0] burst_q, burst_d;
`endif

    scsi_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .zero_o      (tmr_zero),
        .zero_next_o (tmr_zero_next)
    );

    // Phase sequencing, arbitration and phase-timer loads
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        rw_d       = rw_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef SCSI_BURST_EN
        burst_d    = burst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_elig || dma_elig) begin
                    owner_d    = arb_pick(cpu_elig, dma_elig, last_gnt_q);
                    last_gnt_d = owner_d;
                    rw_d       = (owner_d == GNT_CPU_OWN) ? bus_if.cpu_rw : bus_if.dma_rw;
                    state_d    = ST_SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = SETUP_LD;
`ifdef SCSI_BURST_EN
                    burst_d    = BURST_W'(1);
`endif
                end
            end
            ST_SETUP: begin
                // A withdrawn request aborts before any strobe reaches the WD
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
`ifdef SCSI_BURST_EN
                    // Keep DACK_ low into the next transfer while DMA alone wants the port
                    if (owner_q == GNT_DMA_OWN && dma_elig && !bus_if.cpu_req &&
                        burst_q < BURST_MAX) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                        burst_d  = burst_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, taken from the next phase
    always_comb begin
        gnt_cpu_d = (state_d != ST_IDLE) && (owner_d == GNT_CPU_OWN);
        gnt_dma_d = (state_d != ST_IDLE) && (owner_d == GNT_DMA_OWN);
        cs_n_d    = !gnt_cpu_d;
        dack_n_d  = !gnt_dma_d;
        re_n_d    = !((state_d == ST_STROBE) && rw_d);
        we_n_d    = !((state_d == ST_STROBE) && !rw_d);
        data_le_d = (state_d == ST_STROBE) && rw_d && tmr_zero_next;
        cpu_ack_d = (state_q == ST_STROBE) && (state_d == ST_HOLD) && (owner_q == GNT_CPU_OWN);
        dma_ack_d = (state_q == ST_STROBE) && (state_d == ST_HOLD) && (owner_q == GNT_DMA_OWN);
    end

    // State, ownership and registered outputs. Reset releases the WD pins at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= GNT_CPU_OWN;
            last_gnt_q <= GNT_DMA_OWN;
            rw_q       <= 1'b0;
            gnt_cpu_q  <= 1'b0;
            gnt_dma_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            dack_n_q   <= 1'b1;
            re_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            data_le_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            rw_q       <= rw_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_dma_q  <= gnt_dma_d;
            cs_n_q     <= cs_n_d;
            dack_n_q   <= dack_n_d;
            re_n_q     <= re_n_d;
            we_n_q     <= we_n_d;
            data_le_q  <= data_le_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

`ifdef SCSI_BURST_EN
    // Transfers completed under the current DMA grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign bus_if.gnt_cpu     = gnt_cpu_q;
    assign bus_if.gnt_dma     = gnt_dma_q;
    assign bus_if.scsi_cs_n   = cs_n_q;
    assign bus_if.scsi_dack_n = dack_n_q;
    assign bus_if.scsi_re_n   = re_n_q;
    assign bus_if.scsi_we_n   = we_n_q;
    assign bus_if.data_le     = data_le_q;
    assign bus_if.cpu_ack     = cpu_ack_q;
    assign bus_if.dma_ack     = dma_ack_q;

    a_cs_dack_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(!cs_n_q && !dack_n_q));
    a_re_we_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(!re_n_q && !we_n_q));

endmodule
`default_nettype wire

// File: tb/tb_scsi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scsi_bus_arbiter
// Description : Self-checking bench for scsi_bus_arbiter. Each stimulus step
//               queues the cycle-by-cycle pin pattern that the bus protocol
//               requires. Every negedge pops one entry and compares it with
//               the sampled outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scsi_bus_arbiter;

    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 3;
    localparam int HOLD_CYC   = 1;
    localparam int BURST_LEN  = 4;

    // {gnt_cpu, gnt_dma, cs_n, dack_n, re_n, we_n, data_le, cpu_ack, dma_ack}
    localparam logic [8:0] IDLE_V = 9'b001111000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scsi_bus_arbiter_if bus();

    scsi_bus_arbiter #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .BURST_LEN  (BURST_LEN),
        .CNT_W      (3)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    typedef struct {
        logic [8:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [8:0] obs();
        return {bus.gnt_cpu, bus.gnt_dma, bus.scsi_cs_n, bus.scsi_dack_n,
                bus.scsi_re_n, bus.scsi_we_n, bus.data_le, bus.cpu_ack, bus.dma_ack};
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (gc gd cs dk re we le ca da)", tag, got, exp);
        end
    endtask

    // Pin pattern while a transfer owns the port
    function automatic logic [8:0] mk(input bit dma, input bit strb, input bit rd,
                                      input bit le, input bit ack);
        return {~dma, dma, dma, ~dma, ~(strb & rd), ~(strb & ~rd), le, ack & ~dma, ack & dma};
    endfunction

    task automatic push(input logic [8:0] v, input string tag);
        exp_t e;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_xfer(input bit dma, input bit rd, input string name);
        for (int i = 0; i < SETUP_CYC; i++)
            push(mk(dma, 1'b0, rd, 1'b0, 1'b0), $sformatf("%s.setup%0d", name, i));
        for (int i = 0; i < STROBE_CYC; i++)
            push(mk(dma, 1'b1, rd, rd && (i == STROBE_CYC - 1), 1'b0),
                 $sformatf("%s.strobe%0d", name, i));
        for (int i = 0; i < HOLD_CYC; i++)
            push(mk(dma, 1'b0, rd, 1'b0, i == 0), $sformatf("%s.hold%0d", name, i));
    endtask

    task automatic push_idle(input int n, input string name);
        for (int i = 0; i < n; i++)
            push(IDLE_V, $sformatf("%s.idle%0d", name, i));
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(), e.exp);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step();
    endtask

    initial begin
        rst         = 1'b1;
        bus.cpu_req = 1'b0;
        bus.cpu_rw  = 1'b0;
        bus.dma_req = 1'b0;
        bus.dma_rw  = 1'b0;
        bus.dma_en  = 1'b0;
        @(negedge clk);
        check_eq("reset", obs(), IDLE_V);
        rst = 1'b0;
        push_idle(2, "post_reset");
        drain();

        // CPU register read
        bus.cpu_req = 1'b1;
        bus.cpu_rw  = 1'b1;
        push_xfer(1'b0, 1'b1, "cpu_rd");
        drain();
        bus.cpu_req = 1'b0;
        push_idle(2, "cpu_rd_tail");
        drain();

        // DMA write
        bus.dma_en  = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_rw  = 1'b0;
        push_xfer(1'b1, 1'b0, "dma_wr");
        drain();
        bus.dma_req = 1'b0;
        push_idle(2, "dma_wr_tail");
        drain();

        // Two rounds of simultaneous requests: CPU, DMA, CPU, DMA
        for (int r = 0; r < 2; r++) begin
            bus.cpu_req = 1'b1;
            bus.cpu_rw  = 1'b0;
            bus.dma_req = 1'b1;
            bus.dma_rw  = 1'b1;
            push_xfer(1'b0, 1'b0, $sformatf("tie%0d_cpu", r));
            push_idle(1, $sformatf("tie%0d_gap", r));
            push_xfer(1'b1, 1'b1, $sformatf("tie%0d_dma", r));
            drain();
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
            push_idle(2, $sformatf("tie%0d_tail", r));
            drain();
        end

        // CPU withdraws in SETUP: no strobe and no ack
        bus.cpu_req = 1'b1;
        bus.cpu_rw  = 1'b1;
        push(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "abort.setup");
        drain();
        bus.cpu_req = 1'b0;
        push_idle(3, "abort_tail");
        drain();

        // The aborted grant still counts, so the next tie goes to DMA
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_rw  = 1'b0;
        push_xfer(1'b1, 1'b0, "post_abort_dma");
        drain();
        bus.dma_req = 1'b0;
        push_idle(1, "post_abort_gap");
        push_xfer(1'b0, 1'b1, "post_abort_cpu");
        drain();
        bus.cpu_req = 1'b0;
        push_idle(2, "post_abort_tail");
        drain();

        // DREQ is ignored while DMA is disabled
        bus.dma_en  = 1'b0;
        bus.dma_req = 1'b1;
        push_idle(6, "dma_dis");
        drain();

        // DMA_EN dropping mid-transfer lets the transfer finish
        bus.dma_en = 1'b1;
        bus.dma_rw = 1'b1;
        push_xfer(1'b1, 1'b1, "dma_en_drop");
        step();
        step();
        bus.dma_en = 1'b0;
        drain();
        bus.dma_req = 1'b0;
        push_idle(3, "dma_en_drop_tail");
        drain();

`ifdef SCSI_BURST_EN
        // Held DREQ bursts BURST_LEN transfers with DACK_ low throughout
        bus.dma_en  = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_rw  = 1'b1;
        for (int k = 0; k < BURST_LEN; k++)
            push_xfer(1'b1, 1'b1, $sformatf("burst%0d", k));
        drain();
        bus.dma_req = 1'b0;
        push_idle(2, "burst_tail");
        drain();

        // A CPU request after the second ack ends the burst, and the CPU is granted next
        bus.dma_req = 1'b1;
        bus.dma_rw  = 1'b0;
        push_xfer(1'b1, 1'b0, "brk0");
        push_xfer(1'b1, 1'b0, "brk1");
        drain();
        bus.cpu_req = 1'b1;
        bus.cpu_rw  = 1'b0;
        push_idle(1, "brk_gap");
        push_xfer(1'b0, 1'b0, "brk_cpu");
        drain();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        push_idle(2, "brk_tail");
        drain();
`else
        // Without bursts, a held DREQ still turns the bus around between transfers
        bus.dma_en  = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_rw  = 1'b1;
        push_xfer(1'b1, 1'b1, "held0");
        push_idle(1, "held_gap");
        push_xfer(1'b1, 1'b1, "held1");
        drain();
        bus.dma_req = 1'b0;
        push_idle(2, "held_tail");
        drain();
`endif

        // Reset mid-STROBE releases every pin at once and suppresses the ack
        bus.cpu_req = 1'b1;
        bus.cpu_rw  = 1'b1;
        push_xfer(1'b0, 1'b1, "rst_mid");
        step();
        step();
        #2 rst = 1'b1;
        #1 check_eq("rst_async", obs(), IDLE_V);
        sb.delete();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_idle(4, "post_rst");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
